// File: rtl/fpaddsub_normround_pipe.sv
// Normalize-and-round back end for a single-precision add/sub datapath.
// S1 registers the normalized mantissa, exponent and G/R/S bits.
// S2 rounds to nearest even, detects overflow/underflow and registers the
// packed IEEE-754 result together with its flags.
// Optional feature: define FPADDSUB_INEXACT_FLAG_EN to add the Inexact output.
module fpaddsub_normround_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [24:0] Sum,
  input  logic        GuardBit,
  input  logic        RoundBit,
  input  logic        StickyBit,
  input  logic        Sign,
  input  logic [7:0]  Emax,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] Result,
  output logic        Overflow,
  output logic        Underflow,
  output logic        Zero
`ifdef FPADDSUB_INEXACT_FLAG_EN
  ,
  output logic        Inexact
`endif
);

  // Handshake control
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s1_load;
  logic s2_load;

  // S1 state: normalized operand
  logic [23:0]       s1_mant_q;
  logic              s1_g_q;
  logic              s1_r_q;
  logic              s1_s_q;
  logic              s1_sign_q;
  logic              s1_zero_q;
  logic signed [9:0] s1_exp_q;

  // Normalizer combinational results
  logic [4:0]        lz;
  logic [25:0]       norm_shift;
  logic [23:0]       norm_mant;
  logic              norm_g;
  logic              norm_r;
  logic              norm_s;
  logic              norm_zero;
  logic signed [9:0] norm_exp;

  // Rounder combinational results
  logic              rnd_inc;
  logic              rnd_carry;
  logic [22:0]       rnd_frac;
  logic signed [9:0] rnd_exp;
  logic [31:0]       pack_result;
  logic              pack_ovf;
  logic              pack_unf;
  logic              pack_zero;

  // S2 state: packed result and flags
  logic [31:0] result_q;
  logic        ovf_q;
  logic        unf_q;
  logic        zero_q;

`ifdef FPADDSUB_INEXACT_FLAG_EN
  logic pack_inexact;
  logic inexact_q;
`endif

  // Accept whenever S1 is free or will move on this cycle.
  assign in_ready = ~s1_valid_q | ~s2_valid_q | out_ready;
  assign s1_load  = in_valid & in_ready;
  assign s2_load  = s1_valid_q & (~s2_valid_q | out_ready);

  // Next-state of the two stage valid bits
  always_comb begin
    s1_valid_d = s1_valid_q;
    if (s1_load) begin
      s1_valid_d = 1'b1;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    s2_valid_d = s2_valid_q;
    if (s2_load) begin
      s2_valid_d = 1'b1;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  // Leading-zero count of Sum[23:0]; 24 when all zero
  always_comb begin
    lz = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (Sum[i]) begin
        lz = 5'(23 - i);
      end
    end
  end

  // G then R are shifted into the mantissa, zeros after that.
  assign norm_shift = {Sum[23:0], GuardBit, RoundBit} << lz;

  // Normalize: right shift by one on carry, otherwise left shift by lz
  always_comb begin
    norm_zero = (Sum == 25'd0) & ~GuardBit & ~RoundBit & ~StickyBit;
    if (Sum[24]) begin
      norm_mant = Sum[24:1];
      norm_g    = Sum[0];
      norm_r    = GuardBit;
      norm_s    = RoundBit | StickyBit;
      norm_exp  = $signed({2'b00, Emax}) + 10'sd1;
    end else begin
      norm_mant = norm_shift[25:2];
      norm_g    = norm_shift[1];
      norm_r    = norm_shift[0];
      norm_s    = StickyBit;
      norm_exp  = $signed({2'b00, Emax}) - $signed({5'b00000, lz});
    end
  end

  // S1 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_mant_q  <= 24'd0;
      s1_g_q     <= 1'b0;
      s1_r_q     <= 1'b0;
      s1_s_q     <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_exp_q   <= 10'sd0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_load) begin
        s1_mant_q <= norm_mant;
        s1_g_q    <= norm_g;
        s1_r_q    <= norm_r;
        s1_s_q    <= norm_s;
        s1_sign_q <= Sign;
        s1_zero_q <= norm_zero;
        s1_exp_q  <= norm_exp;
      end
    end
  end

  // Round to nearest even; an all-ones mantissa carries into the exponent
  // and the 23-bit fraction wraps to zero, i.e. mantissa 0x800000.
  assign rnd_inc   = s1_g_q & (s1_r_q | s1_s_q | s1_mant_q[0]);
  assign rnd_carry = rnd_inc & (&s1_mant_q);
  assign rnd_frac  = s1_mant_q[22:0] + {22'd0, rnd_inc};
  assign rnd_exp   = s1_exp_q + $signed({9'd0, rnd_carry});

  // Pack the result and resolve the exceptional cases
  always_comb begin
    pack_result = {s1_sign_q, rnd_exp[7:0], rnd_frac};
    pack_ovf    = 1'b0;
    pack_unf    = 1'b0;
    pack_zero   = 1'b0;
    if (s1_zero_q) begin
      pack_result = 32'h0000_0000;
      pack_zero   = 1'b1;
    end else if (rnd_exp >= 10'sd255) begin
      pack_result = {s1_sign_q, 8'hFF, 23'd0};
      pack_ovf    = 1'b1;
    end else if (rnd_exp <= 10'sd0) begin
      // Denormals are flushed to a signed zero.
      pack_result = {s1_sign_q, 31'd0};
      pack_unf    = 1'b1;
      pack_zero   = 1'b1;
    end
  end

`ifdef FPADDSUB_INEXACT_FLAG_EN
  // Any discarded bit or exceptional clamp makes the result inexact.
  assign pack_inexact = ~s1_zero_q & (s1_g_q | s1_r_q | s1_s_q | pack_ovf | pack_unf);
`endif

  // S2 register: holds its contents while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      result_q   <= 32'd0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      zero_q     <= 1'b0;
`ifdef FPADDSUB_INEXACT_FLAG_EN
      inexact_q  <= 1'b0;
`endif
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s2_load) begin
        result_q  <= pack_result;
        ovf_q     <= pack_ovf;
        unf_q     <= pack_unf;
        zero_q    <= pack_zero;
`ifdef FPADDSUB_INEXACT_FLAG_EN
        inexact_q <= pack_inexact;
`endif
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign Result    = result_q;
  assign Overflow  = ovf_q;
  assign Underflow = unf_q;
  assign Zero      = zero_q;
`ifdef FPADDSUB_INEXACT_FLAG_EN
  assign Inexact   = inexact_q;
`endif

endmodule

// File: doc/fpaddsub_normround_pipe.md
FPADDSUB_NORMROUND_PIPE -- requirements
Module: fpaddsub_normround_pipe

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port in_valid, input, 1 bit: the execute-stage result on the in_* ports is valid.
REQ-004 SHALL have port in_ready, output, 1 bit: this block accepts the input this cycle.
REQ-005 SHALL have port Sum, input, 25 bits: raw mantissa sum; bit 24 is the carry.
REQ-006 SHALL have ports GuardBit, RoundBit and StickyBit, inputs, 1 bit each: guard, round and sticky bits from the execute stage.
REQ-007 SHALL have port Sign, input, 1 bit: result sign, already resolved upstream.
REQ-008 SHALL have port Emax, input, 8 bits: biased exponent of the larger operand, range 1..254.
REQ-009 SHALL have port out_valid, output, 1 bit: Result and flags are valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the output.
REQ-011 SHALL have port Result, output, 32 bits: IEEE-754 single-precision sum.
REQ-012 SHALL have ports Overflow, Underflow and Zero, outputs, 1 bit each: status flags qualified by out_valid.

Function
REQ-013 SHALL be a 2-stage pipeline: S1 normalizes, S2 rounds and packs; latency is 2 cycles from acceptance to out_valid when not stalled.
REQ-014 SHALL transfer on the input side when in_valid&in_ready, and on the output side when out_valid&out_ready.
REQ-015 SHALL drive in_ready = !S1_valid | !S2_valid | out_ready, so one transfer per cycle is sustained.
REQ-016 SHALL advance S1 into S2 when S2 is empty or draining; S2 holds Result and flags stable while out_valid&!out_ready.
REQ-017 S1 carry case (Sum[24]=1): mantissa = Sum[24:1]; G'=Sum[0]; R'=G; S'=R|S; exponent = Emax+1.
REQ-018 S1 otherwise: lz = leading zeros of Sum[23:0] (0..24); shift left by lz, shifting in G, then R, then zeros; S' = S; exponent = Emax-lz (10-bit signed internal).
REQ-019 S1 zero case (Sum, G, R and S all 0): the entry SHALL produce Result = 0x00000000 with Zero=1 in S2.
REQ-020 S2 SHALL round to nearest even: increment when G'&(R'|S'|mant[0]).
REQ-021 S2 rounding carry-out SHALL set the mantissa to 0x800000 and increment the exponent by 1.
REQ-022 S2 with final exponent >= 255 SHALL output {Sign, 0xFF, 0} with Overflow=1.
REQ-023 S2 with final exponent <= 0 SHALL output {Sign, 31'b0} with Underflow=1 and Zero=1; denormals are flushed.
REQ-024 Result SHALL be {Sign, exp[7:0], mant[22:0]}; flags are mutually exclusive except Underflow with Zero.
REQ-025 Simultaneous accept and emit in one cycle SHALL preserve order with no loss or duplication.

Reset
REQ-026 While rst_n=0, SHALL clear S1_valid, S2_valid and out_valid, and drive Result = 0, all flags = 0 and in_ready = 1.
REQ-027 Reset mid-operation SHALL discard in-flight entries; the first output after release comes from the first post-reset acceptance.

Configuration
REQ-028 With macro FPADDSUB_INEXACT_FLAG_EN defined, SHALL add output port Inexact, 1 bit, = G'|R'|S' | Overflow | Underflow (excluding the exact-zero case), pipelined with Result; reset value 0.
REQ-029 Without FPADDSUB_INEXACT_FLAG_EN, the Inexact port and its logic SHALL be absent, and all other behaviour is identical.

Verification
REQ-030 Sum=25'h1000000, GRS=0, Emax=127, Sign=0 -> after 2 cycles Result=0x40000000, no flags.
REQ-031 Sum=25'h0400000, Emax=127 -> Result=0x3F000000.
REQ-032 Sum=25'h0800001, G=1, R=0, S=0, Emax=127 -> Result=0x3F800002 (round up); Sum=25'h0800000 with the same GRS -> 0x3F800000 (tie kept even).
REQ-033 Sum=25'h1FFFFFE, Emax=254 -> Result=0x7F800000 with Overflow=1; Sum=0 with GRS=0 -> 0x00000000 with Zero=1.
REQ-034 Three back-to-back inputs with out_ready=0 for 4 cycles -> in_ready drops after 2 acceptances; on release, outputs appear in order with values unchanged.
REQ-035 Assert rst_n=0 with both stages full -> out_valid=0 asynchronously; after release, no stale output appears.
